// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// state encoding, opcode/funct constants, and ALU/PC-source encodings.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Handshake and control bundle between the sequencer and the datapath/memories.
interface mc_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [5:0]       op_i;
  logic [5:0]       func_i;
  logic             zero_i;
  logic             imem_ack_i;
  logic             dmem_ack_i;
  logic             imem_req_o;
  logic             ir_we_o;
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic             rf_we_o;
  logic             rf_dst_o;
  logic             wb_sel_o;
  logic             alu_src_o;
  logic [3:0]       alu_op_o;
  logic             pc_we_o;
  logic [1:0]       pc_src_o;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  start_i, op_i, func_i, zero_i, imem_ack_i, dmem_ack_i,
    output imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, rf_dst_o,
           wb_sel_o, alu_src_o, alu_op_o, pc_we_o, pc_src_o, busy_o, err_o,
           retired_o
  );

  modport slave (
    output start_i, op_i, func_i, zero_i, imem_ack_i, dmem_ack_i,
    input  imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, rf_dst_o,
           wb_sel_o, alu_src_o, alu_op_o, pc_we_o, pc_src_o, busy_o, err_o,
           retired_o
  );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational opcode/funct decoder: ALU operation plus a legal-instruction flag.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output alu_op_e    alu_op_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b0;
    case (op_i)
      OP_R: begin
        case (func_i)
          FN_ADD: begin alu_op_o = ALU_ADD; legal_o = 1'b1; end
          FN_SUB: begin alu_op_o = ALU_SUB; legal_o = 1'b1; end
          FN_AND: begin alu_op_o = ALU_AND; legal_o = 1'b1; end
          FN_OR:  begin alu_op_o = ALU_OR;  legal_o = 1'b1; end
          FN_SLT: begin alu_op_o = ALU_SLT; legal_o = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: legal_o = 1'b1;
      OP_BEQ: begin alu_op_o = ALU_SUB; legal_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ack timeout.
// Define ILLEGAL_TRAP_EN to trap illegal instructions (trap_o, HALT) instead of running them as NOPs.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input logic  clk_i,
  input logic  rst_i,
  mc_if.master bus
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic trap_o
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [5:0]         func_q, func_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               err_q, err_d;
  logic               timeout;
`ifdef ILLEGAL_TRAP_EN
  logic               trap_q, trap_d;
`endif

  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, rf_dst, wb_sel, alu_src, pc_we, retire;
  alu_op_e    alu_op;
  pc_src_e    pc_src;
  logic [5:0] dec_op, dec_func;
  alu_op_e    dec_alu_op;
  logic       dec_legal;

  // In DECODE the IR is checked directly; afterwards the latched copy drives decoding.
  assign dec_op   = (state_q == S_DECODE) ? bus.op_i   : op_q;
  assign dec_func = (state_q == S_DECODE) ? bus.func_i : func_q;

  mc_alu_dec u_dec (
    .op_i     (dec_op),
    .func_i   (dec_func),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  assign wait_inc = wait_q + WAIT_W'(1);
  assign timeout  = (wait_inc == WAIT_W'(MAX_WAIT));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    func_d   = func_q;
    wait_d   = wait_q;
    err_d    = err_q;
`ifdef ILLEGAL_TRAP_EN
    trap_d   = trap_q;
`endif
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_dst   = 1'b0;
    wb_sel   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    pc_we    = 1'b0;
    pc_src   = PC_SEQ;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack_i) begin
          ir_we   = 1'b1;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (timeout) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d  = wait_inc;
        end
      end
      S_DECODE: begin
        op_d   = bus.op_i;
        func_d = bus.func_i;
        if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = S_HALT;
`else
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = (op_q == OP_ADDI) || is_mem_op(op_q);
        if (op_q == OP_BEQ) begin
          pc_we   = 1'b1;
          pc_src  = bus.zero_i ? PC_BRANCH : PC_SEQ;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op_q == OP_J) begin
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem_op(op_q)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        if (bus.dmem_ack_i) begin
          wait_d = '0;
          if (op_q == OP_SW) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d  = wait_inc;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_dst  = (op_q == OP_R);
        wb_sel  = (op_q == OP_LW);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      func_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign bus.imem_req_o = imem_req;
  assign bus.ir_we_o    = ir_we;
  assign bus.dmem_req_o = dmem_req;
  assign bus.dmem_we_o  = dmem_we;
  assign bus.rf_we_o    = rf_we;
  assign bus.rf_dst_o   = rf_dst;
  assign bus.wb_sel_o   = wb_sel;
  assign bus.alu_src_o  = alu_src;
  assign bus.alu_op_o   = alu_op;
  assign bus.pc_we_o    = pc_we;
  assign bus.pc_src_o   = pc_src;
  assign bus.busy_o     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.err_o      = err_q;
  assign bus.retired_o  = retired_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap_o         = trap_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: instruction classes, memory latency,
// timeout, mid-instruction reset, and illegal-opcode handling.
module tb_mc_ctrl;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;
  int   expRetired;
`ifdef ILLEGAL_TRAP_EN
  logic trap;
`endif

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] aluOp;
    logic       src;
    logic       dst;
  } vec_t;

  vec_t vecs[5];

  mc_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.CNT_W(32), .MAX_WAIT(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
`ifdef ILLEGAL_TRAP_EN
    ,
    .trap_o(trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [5:0] op, input logic [5:0] fn,
                               input logic zero, input logic iack, input logic dack);
    bus.start_i    = start;
    bus.op_i       = op;
    bus.func_i     = fn;
    bus.zero_i     = zero;
    bus.imem_ack_i = iack;
    bus.dmem_ack_i = dack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    expRetired = 0;
  endtask

  // Leaves the controller in FETCH, one cycle after start is seen in IDLE.
  task automatic startRun();
    applyStimulus(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Called in FETCH; acks on the delay-th FETCH cycle and returns in DECODE.
  task automatic fetchInstr(input logic [5:0] op, input logic [5:0] fn, input int delay);
    for (int c = 1; c < delay; c++) begin
      applyStimulus(1'b0, op, fn, 1'b0, 1'b0, 1'b0);
      checkOutput("fetch_req_wait", 32'(bus.imem_req_o), 1);
      checkOutput("fetch_irwe_wait", 32'(bus.ir_we_o), 0);
      tick();
    end
    applyStimulus(1'b0, op, fn, 1'b0, 1'b1, 1'b0);
    checkOutput("fetch_irwe_ack", 32'(bus.ir_we_o), 1);
    tick();
    applyStimulus(1'b0, op, fn, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    expRetired = 0;
    vecs[0] = '{6'h00, 6'h22, 4'd1, 1'b0, 1'b1};
    vecs[1] = '{6'h00, 6'h24, 4'd2, 1'b0, 1'b1};
    vecs[2] = '{6'h00, 6'h25, 4'd3, 1'b0, 1'b1};
    vecs[3] = '{6'h00, 6'h2A, 4'd4, 1'b0, 1'b1};
    vecs[4] = '{6'h08, 6'h00, 4'd0, 1'b1, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #7;
    checkOutput("rst_busy", 32'(bus.busy_o), 0);
    checkOutput("rst_imem_req", 32'(bus.imem_req_o), 0);
    checkOutput("rst_pc_we", 32'(bus.pc_we_o), 0);
    checkOutput("rst_pc_src", 32'(bus.pc_src_o), 0);
    checkOutput("rst_alu_op", 32'(bus.alu_op_o), 0);
    checkOutput("rst_err", 32'(bus.err_o), 0);
    checkOutput("rst_retired", bus.retired_o, 0);
    rst_n = 1'b1;

    $display("[TB] add with imem ack on third FETCH cycle");
    startRun();
    checkOutput("add_busy", 32'(bus.busy_o), 1);
    fetchInstr(6'h00, 6'h20, 3);
    checkOutput("add_dec_pc_we", 32'(bus.pc_we_o), 0);
    tick();
    checkOutput("add_ex_alu_op", 32'(bus.alu_op_o), 0);
    checkOutput("add_ex_alu_src", 32'(bus.alu_src_o), 0);
    checkOutput("add_ex_rf_we", 32'(bus.rf_we_o), 0);
    tick();
    checkOutput("add_wb_rf_we", 32'(bus.rf_we_o), 1);
    checkOutput("add_wb_rf_dst", 32'(bus.rf_dst_o), 1);
    checkOutput("add_wb_wb_sel", 32'(bus.wb_sel_o), 0);
    checkOutput("add_wb_pc_we", 32'(bus.pc_we_o), 1);
    checkOutput("add_wb_retired", bus.retired_o, 0);
    tick();
    expRetired = 1;
    checkOutput("add_retired", bus.retired_o, 32'(expRetired));
    checkOutput("add_next_fetch", 32'(bus.imem_req_o), 1);
    checkOutput("add_rf_we_off", 32'(bus.rf_we_o), 0);

    $display("[TB] lw with dmem ack on third MEM cycle");
    fetchInstr(6'h23, 6'h00, 1);
    tick();
    checkOutput("lw_ex_alu_src", 32'(bus.alu_src_o), 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, (c == 2) ? 1'b1 : 1'b0);
      checkOutput("lw_mem_req", 32'(bus.dmem_req_o), 1);
      checkOutput("lw_mem_we", 32'(bus.dmem_we_o), 0);
      checkOutput("lw_mem_pc_we", 32'(bus.pc_we_o), 0);
      tick();
    end
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_wb_rf_we", 32'(bus.rf_we_o), 1);
    checkOutput("lw_wb_rf_dst", 32'(bus.rf_dst_o), 0);
    checkOutput("lw_wb_wb_sel", 32'(bus.wb_sel_o), 1);
    checkOutput("lw_wb_dmem_req", 32'(bus.dmem_req_o), 0);
    tick();
    expRetired++;
    checkOutput("lw_retired", bus.retired_o, 32'(expRetired));

    $display("[TB] sw with immediate dmem ack");
    fetchInstr(6'h2B, 6'h00, 1);
    tick();
    checkOutput("sw_ex_alu_src", 32'(bus.alu_src_o), 1);
    tick();
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("sw_mem_req", 32'(bus.dmem_req_o), 1);
    checkOutput("sw_mem_we", 32'(bus.dmem_we_o), 1);
    checkOutput("sw_mem_pc_we", 32'(bus.pc_we_o), 1);
    checkOutput("sw_mem_rf_we", 32'(bus.rf_we_o), 0);
    tick();
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
    expRetired++;
    checkOutput("sw_retired", bus.retired_o, 32'(expRetired));
    checkOutput("sw_fetch_rf_we", 32'(bus.rf_we_o), 0);

    $display("[TB] beq taken, beq not taken, jump");
    for (int k = 0; k < 3; k++) begin
      logic [5:0] op;
      logic       z;
      op = (k == 2) ? 6'h02 : 6'h04;
      z  = (k == 0) ? 1'b1 : 1'b0;
      fetchInstr(op, 6'h00, 1);
      tick();
      applyStimulus(1'b0, op, 6'h00, z, 1'b0, 1'b0);
      checkOutput("br_pc_we", 32'(bus.pc_we_o), 1);
      checkOutput("br_pc_src", 32'(bus.pc_src_o), (k == 0) ? 1 : (k == 1) ? 0 : 2);
      checkOutput("br_rf_we", 32'(bus.rf_we_o), 0);
      if (k < 2) checkOutput("beq_alu_op", 32'(bus.alu_op_o), 1);
      tick();
      expRetired++;
      checkOutput("br_retired", bus.retired_o, 32'(expRetired));
      checkOutput("br_fetch", 32'(bus.imem_req_o), 1);
    end

    $display("[TB] R-type and addi ALU decode");
    for (int i = 0; i < 5; i++) begin
      fetchInstr(vecs[i].op, vecs[i].fn, 1);
      tick();
      checkOutput("alu_op", 32'(bus.alu_op_o), 32'(vecs[i].aluOp));
      checkOutput("alu_src", 32'(bus.alu_src_o), 32'(vecs[i].src));
      tick();
      checkOutput("alu_wb_rf_we", 32'(bus.rf_we_o), 1);
      checkOutput("alu_wb_rf_dst", 32'(bus.rf_dst_o), 32'(vecs[i].dst));
      tick();
      expRetired++;
    end
    checkOutput("alu_retired", bus.retired_o, 32'(expRetired));

    $display("[TB] illegal opcode 0x3F");
    fetchInstr(6'h3F, 6'h00, 1);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill_pc_we", 32'(bus.pc_we_o), 0);
    tick();
    checkOutput("ill_trap", 32'(trap), 1);
    checkOutput("ill_busy", 32'(bus.busy_o), 0);
    checkOutput("ill_retired", bus.retired_o, 32'(expRetired));
`else
    checkOutput("ill_pc_we", 32'(bus.pc_we_o), 1);
    checkOutput("ill_pc_src", 32'(bus.pc_src_o), 0);
    checkOutput("ill_rf_we", 32'(bus.rf_we_o), 0);
    tick();
    expRetired++;
    checkOutput("ill_retired", bus.retired_o, 32'(expRetired));
    checkOutput("ill_fetch", 32'(bus.imem_req_o), 1);
`endif

    $display("[TB] imem timeout");
    resetDut();
    checkOutput("to_rst_retired", bus.retired_o, 0);
    startRun();
    for (int c = 1; c < 16; c++) begin
      applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("to_c16_busy", 32'(bus.busy_o), 1);
    checkOutput("to_c16_err", 32'(bus.err_o), 0);
    tick();
    checkOutput("to_halt_busy", 32'(bus.busy_o), 0);
    checkOutput("to_halt_err", 32'(bus.err_o), 1);
    checkOutput("to_halt_req", 32'(bus.imem_req_o), 0);
    applyStimulus(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("to_ign_busy", 32'(bus.busy_o), 0);
    checkOutput("to_ign_req", 32'(bus.imem_req_o), 0);
    checkOutput("to_ign_irwe", 32'(bus.ir_we_o), 0);
    checkOutput("to_ign_err", 32'(bus.err_o), 1);
    resetDut();
    checkOutput("to_rst_err", 32'(bus.err_o), 0);

    $display("[TB] imem ack on the limit cycle");
    startRun();
    for (int c = 1; c < 16; c++) begin
      applyStimulus(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    fetchInstr(6'h02, 6'h00, 1);
    checkOutput("lim_dec_busy", 32'(bus.busy_o), 1);
    checkOutput("lim_dec_err", 32'(bus.err_o), 0);
    tick();
    checkOutput("lim_j_pc_src", 32'(bus.pc_src_o), 2);
    tick();
    checkOutput("lim_retired", bus.retired_o, 1);
    checkOutput("lim_err", 32'(bus.err_o), 0);

    $display("[TB] reset during sw MEM");
    resetDut();
    startRun();
    fetchInstr(6'h2B, 6'h00, 1);
    tick();
    tick();
    checkOutput("rmem_req", 32'(bus.dmem_req_o), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmem_req_drop", 32'(bus.dmem_req_o), 0);
    checkOutput("rmem_we_drop", 32'(bus.dmem_we_o), 0);
    checkOutput("rmem_pc_we", 32'(bus.pc_we_o), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("rmem_busy", 32'(bus.busy_o), 0);
    checkOutput("rmem_retired", bus.retired_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath: instruction fetch, decode, register file, ALU, data memory and PC.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories that have variable latency.
- Drives the PC, IR, register-file and memory enables, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MAX_WAIT, 16, memory-ack timeout in cycles before the controller flags a stall error.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin execution from IDLE (level; sampled in IDLE only).
- op_i  in  6  instr[31:26] from the IR.
- func_i  in  6  instr[5:0] from the IR.
- zero_i  in  1  ALU zero flag.
- imem_ack_i  in  1  instruction word valid on IR input this cycle.
- dmem_ack_i  in  1  data memory read data valid / write done.
- imem_req_o  out  1  instruction fetch request.
- ir_we_o  out  1  load the IR.
- dmem_req_o  out  1  data memory request.
- dmem_we_o  out  1  data memory write (qualifies dmem_req_o).
- rf_we_o  out  1  register-file write enable.
- rf_dst_o  out  1  0 = rt, 1 = rd.
- wb_sel_o  out  1  0 = ALU result, 1 = memory data.
- alu_src_o  out  1  0 = rt register, 1 = sign-extended immediate.
- alu_op_o  out  4  0=ADD 1=SUB 2=AND 3=OR 4=SLT.
- pc_we_o  out  1  PC update enable.
- pc_src_o  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- busy_o  out  1  high in every state except IDLE and HALT.
- err_o  out  1  sticky memory-timeout flag.
- retired_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, rst_i=0):
  - state=IDLE; op/func latches, wait counter, retired_o and err_o cleared.
  - All enables and requests are 0; pc_src_o=0, alu_op_o=0.
  - Reset asserted mid-instruction aborts it with no writes.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are decoded combinationally from state plus the latched op/func.
- IDLE: start_i=1 -> FETCH.
- FETCH:
  - imem_req_o=1 held until imem_ack_i.
  - On ack: ir_we_o=1 in the same cycle -> DECODE.
- DECODE (1 cycle):
  - Latch op_i/func_i.
  - Unknown opcode, or R-type with unknown funct -> treated as NOP: pc_we_o=1, pc_src_o=0, retire -> FETCH.
- EXEC (1 cycle):
  - R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - addi 0x08: alu_src_o=1, ADD.
  - lw 0x23 / sw 0x2B: alu_src_o=1, ADD -> MEM.
  - beq 0x04: SUB; pc_we_o=1; pc_src_o=1 if zero_i else 0; retire -> FETCH.
  - j 0x02: pc_we_o=1, pc_src_o=2; retire -> FETCH.
  - R-type/addi -> WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for sw. Held until dmem_ack_i.
  - sw: on ack, pc_we_o=1, retire -> FETCH.
  - lw: on ack -> WB.
- WB (1 cycle):
  - rf_we_o=1; rf_dst_o=1 for R-type, 0 otherwise; wb_sel_o=1 for lw.
  - pc_we_o=1, pc_src_o=0; retire -> FETCH.
  - A write to register 0 is still issued; the register file ignores it.
- Retire: retired_o increments by 1 in the retiring cycle and wraps at 2^CNT_W-1 -> 0.
- Memory timeout:
  - The wait counter counts FETCH/MEM cycles without ack.
  - When it reaches MAX_WAIT: err_o=1 (sticky until reset), state -> HALT.
  - An ack arriving in the same cycle as the limit wins; no error.
- HALT: absorbing; all enables 0; left only by reset.
- start_i is ignored outside IDLE. Acks outside FETCH/MEM are ignored.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode/funct in DECODE asserts extra output trap_o (1 bit, sticky, reset 0), goes to HALT, does not retire, and issues no PC update.
- Undefined: the trap_o port is absent and illegal instructions execute as NOPs as described above.

Decomposition:
- Shared package mc_pkg:
  - state encoding.
  - opcode constants: R 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - funct constants: 0x20/0x22/0x24/0x25/0x2A.
  - alu_op and pc_src encodings.
- Sub-module mc_alu_dec: combinational op/func -> alu_op_o and legal flag. It is reused by the datapath ALU and the trap logic.

Test Plan:
- add (op 0, funct 0x20), imem ack after 3 cycles: FETCH held 3 cycles; exactly 1 rf_we_o pulse with rf_dst_o=1; retired_o 0->1; 6 cycles from start to retire.
- lw (0x23), dmem_ack delayed 2 cycles: dmem_req_o=1 and dmem_we_o=0 for 3 cycles; WB with wb_sel_o=1, rf_dst_o=0; sw (0x2B): dmem_we_o=1, no rf_we_o.
- beq with zero_i=1 -> pc_src_o=1, pc_we_o=1 in EXEC; beq with zero_i=0 -> pc_src_o=0; j (0x02) -> pc_src_o=2; none assert rf_we_o.
- imem_ack_i never asserted, MAX_WAIT=16: err_o=1 and state HALT after 16 FETCH cycles; later start_i and acks ignored; reset clears err_o. Ack in cycle 16 -> no error.
- rst_i pulsed low mid-MEM of sw: dmem_req_o drops asynchronously; after release, IDLE with retired_o=0; no write occurs.
- Opcode 0x3F: without ILLEGAL_TRAP_EN, retires as NOP (retired_o+1, pc_src_o=0); with it, trap_o=1, HALT, retired_o unchanged.
